// File: rtl/hdmi_tmds_enc_mc.sv
// NUM_CH-lane TMDS encoder (video/control/guard/TERC4), 2 ce-cycle latency; all state holds while ce=0, no other backpressure.
// Optional HDMI_TERC4_EN builds the TERC4 data-island table; without it mode 2 is encoded as CTRL from the lane's ctrl bits.
module hdmi_tmds_enc_mc #(
  parameter int NUM_CH = 3,
  parameter int DISP_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [1:0]             mode,
  input  logic [NUM_CH*8-1:0]    data,
  input  logic [NUM_CH*2-1:0]    ctrl,
  input  logic [NUM_CH*4-1:0]    terc4,
  output logic [NUM_CH*10-1:0]   enc,
  output logic                   enc_vld
);

  typedef enum logic [1:0] {
    M_CTRL   = 2'd0,
    M_VIDEO  = 2'd1,
    M_ISLAND = 2'd2,
    M_GUARD  = 2'd3
  } mode_e;

  localparam logic [9:0]        CTRL0      = 10'b1101010100;
  localparam logic [9:0]        GUARD_EVEN = 10'b1011001100;
  localparam logic [9:0]        GUARD_ODD  = 10'b0100110011;
  localparam logic [DISP_W-1:0] TWO        = DISP_W'(2);
  localparam logic [DISP_W-1:0] EIGHT      = DISP_W'(8);

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) n = n + {3'd0, v[k]};
    return n;
  endfunction

  // Transition-minimising stage: q_m[8]=1 marks the XOR chain, 0 the XNOR chain.
  function automatic logic [8:0] tmds_qm(input logic [7:0] d);
    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;
    n1       = ones8(d);
    use_xnor = (n1 > 4'd4) || (n1 == 4'd4 && !d[0]);
    q        = 9'd0;
    q[0]     = d[0];
    for (int k = 1; k < 8; k++) q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
    q[8]     = ~use_xnor;
    return q;
  endfunction

  function automatic logic [9:0] ctrl_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'd0:    s = 10'b1101010100;
      2'd1:    s = 10'b0010101011;
      2'd2:    s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

`ifdef HDMI_TERC4_EN
  function automatic logic [9:0] terc4_sym(input logic [3:0] t);
    logic [9:0] s;
    case (t)
      4'h0:    s = 10'b1010011100;
      4'h1:    s = 10'b1001100011;
      4'h2:    s = 10'b1011100100;
      4'h3:    s = 10'b1011100010;
      4'h4:    s = 10'b0101110001;
      4'h5:    s = 10'b0100011110;
      4'h6:    s = 10'b0110001110;
      4'h7:    s = 10'b0100111100;
      4'h8:    s = 10'b1011001100;
      4'h9:    s = 10'b0100111001;
      4'hA:    s = 10'b0110011100;
      4'hB:    s = 10'b1011000110;
      4'hC:    s = 10'b1010001110;
      4'hD:    s = 10'b1001110001;
      4'hE:    s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction
`else
  logic unused_terc4;
  assign unused_terc4 = ^terc4;
`endif

  // DC-balancing stage. Disparity is two's complement in DISP_W bits; modular
  // arithmetic gives the same bits as signed arithmetic. Returns {symbol, new cnt}.
  function automatic logic [10+DISP_W-1:0] tmds_video(input logic [8:0]        qm,
                                                      input logic [3:0]        n1q,
                                                      input logic [DISP_W-1:0] cnt_in);
    logic [DISP_W-1:0] diff;
    logic [DISP_W-1:0] cnt_out;
    logic [9:0]        sym;
    logic              cnt_neg;
    logic              cnt_pos;
    diff    = DISP_W'({n1q, 1'b0}) - EIGHT;
    cnt_neg = cnt_in[DISP_W-1];
    cnt_pos = !cnt_neg && (cnt_in != '0);
    if (cnt_in == '0 || n1q == 4'd4) begin
      sym     = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt_out = qm[8] ? cnt_in + diff : cnt_in - diff;
    end else if ((cnt_pos && n1q > 4'd4) || (cnt_neg && n1q < 4'd4)) begin
      sym     = {1'b1, qm[8], ~qm[7:0]};
      cnt_out = cnt_in + (qm[8] ? TWO : '0) - diff;
    end else begin
      sym     = {1'b0, qm[8], qm[7:0]};
      cnt_out = cnt_in - (qm[8] ? '0 : TWO) + diff;
    end
    return {sym, cnt_out};
  endfunction

  // Stage 1 registers
  logic              s1_vld;
  mode_e             s1_mode;
  logic [8:0]        s1_qm    [NUM_CH];
  logic [3:0]        s1_n1q   [NUM_CH];
  logic [1:0]        s1_ctrl  [NUM_CH];
`ifdef HDMI_TERC4_EN
  logic [3:0]        s1_terc4 [NUM_CH];
`endif

  // Stage 2 registers
  logic [9:0]        enc_q    [NUM_CH];
  logic [DISP_W-1:0] cnt      [NUM_CH];

  logic [8:0]        qm_c     [NUM_CH];
  logic [9:0]        enc_n    [NUM_CH];
  logic [DISP_W-1:0] cnt_n    [NUM_CH];

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      qm_c[i] = tmds_qm(data[i*8 +: 8]);
    end
  end

  // Every non-video symbol clears the lane disparity, so video restarts balanced after blanking.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      enc_n[i] = CTRL0;
      cnt_n[i] = '0;
      case (s1_mode)
        M_VIDEO:  {enc_n[i], cnt_n[i]} = tmds_video(s1_qm[i], s1_n1q[i], cnt[i]);
`ifdef HDMI_TERC4_EN
        M_ISLAND: enc_n[i] = terc4_sym(s1_terc4[i]);
`endif
        M_GUARD:  enc_n[i] = (i % 2 == 0) ? GUARD_EVEN : GUARD_ODD;
        default:  enc_n[i] = ctrl_sym(s1_ctrl[i]);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_mode <= M_CTRL;
      enc_vld <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_qm[i]    <= '0;
        s1_n1q[i]   <= '0;
        s1_ctrl[i]  <= '0;
`ifdef HDMI_TERC4_EN
        s1_terc4[i] <= '0;
`endif
        enc_q[i]    <= CTRL0;
        cnt[i]      <= '0;
      end
    end else if (ce) begin
      s1_vld  <= 1'b1;
      s1_mode <= mode_e'(mode);
      enc_vld <= s1_vld;
      for (int i = 0; i < NUM_CH; i++) begin
        s1_qm[i]    <= qm_c[i];
        s1_n1q[i]   <= ones8(qm_c[i][7:0]);
        s1_ctrl[i]  <= ctrl[i*2 +: 2];
`ifdef HDMI_TERC4_EN
        s1_terc4[i] <= terc4[i*4 +: 4];
`endif
        enc_q[i]    <= enc_n[i];
        cnt[i]      <= cnt_n[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane_out
    assign enc[g*10 +: 10] = enc_q[g];
  end

endmodule

// File: tb/tb_hdmi_tmds_enc_mc.sv
// Scoreboard bench for hdmi_tmds_enc_mc: a reference encoder queues the expected symbols of every
// ce-qualified pixel; each scenario task pops and compares as the DUT presents outputs.
module tb_hdmi_tmds_enc_mc;
  localparam int NUM_CH = 3;
  localparam int DISP_W = 5;
  localparam logic [1:0] CTRL = 2'd0, VIDEO = 2'd1, ISLAND = 2'd2, GUARD = 2'd3;
  localparam logic [NUM_CH*10-1:0] RST_ENC = {NUM_CH{10'h354}};
`ifdef HDMI_TERC4_EN
  localparam bit TERC4_ON = 1'b1;
`else
  localparam bit TERC4_ON = 1'b0;
`endif

  logic                 clk   = 1'b0;
  logic                 rst   = 1'b1;
  logic                 ce    = 1'b0;
  logic [1:0]           mode  = 2'd0;
  logic [NUM_CH*8-1:0]  data  = '0;
  logic [NUM_CH*2-1:0]  ctrl  = '0;
  logic [NUM_CH*4-1:0]  terc4 = '0;
  logic [NUM_CH*10-1:0] enc;
  logic                 enc_vld;

  always #5 clk = ~clk;

  hdmi_tmds_enc_mc #(.NUM_CH(NUM_CH), .DISP_W(DISP_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .data(data),
    .ctrl(ctrl), .terc4(terc4), .enc(enc), .enc_vld(enc_vld)
  );

  typedef struct packed {
    logic [1:0]           mode;
    logic [NUM_CH*8-1:0]  data;
    logic [NUM_CH*10-1:0] enc;
    logic [NUM_CH*8-1:0]  cnt;
  } item_t;

  item_t                exp_q[$];
  int                   mdisp [NUM_CH];
  int                   ce_edges;
  int                   checks;
  int                   errors;
  logic [NUM_CH*10-1:0] last_enc;
  logic                 last_vld;
  logic [9:0]           ctrl_tab  [4];
  logic [9:0]           terc4_tab [16];

  // Reference encoder written from the DVI algorithm with integer disparity.
  function automatic logic [9:0] ref_sym(input int lane, input logic [1:0] m, input logic [7:0] d,
                                         input logic [1:0] c, input logic [3:0] t, inout int disp);
    logic [8:0] q;
    logic [9:0] s;
    int         n1, ones, zeros, q8;
    bit         xn;
    s = ctrl_tab[c];
    if (m == VIDEO) begin
      n1 = $countones(d);
      xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      q = '0;
      q[0] = d[0];
      for (int k = 1; k < 8; k++) q[k] = xn ? (q[k-1] ~^ d[k]) : (q[k-1] ^ d[k]);
      q[8]  = !xn;
      q8    = int'(q[8]);
      ones  = $countones(q[7:0]);
      zeros = 8 - ones;
      if (disp == 0 || ones == zeros) begin
        s    = q[8] ? {2'b01, q[7:0]} : {2'b10, ~q[7:0]};
        disp = disp + (q[8] ? ones - zeros : zeros - ones);
      end else if ((disp > 0 && ones > zeros) || (disp < 0 && zeros > ones)) begin
        s    = {1'b1, q[8], ~q[7:0]};
        disp = disp + 2*q8 + zeros - ones;
      end else begin
        s    = {1'b0, q[8], q[7:0]};
        disp = disp - 2*(1 - q8) + ones - zeros;
      end
    end else begin
      disp = 0;
      if (m == GUARD) s = (lane % 2 == 0) ? 10'h2CC : 10'h133;
      else if (m == ISLAND) s = TERC4_ON ? terc4_tab[t] : ctrl_tab[c];
    end
    return s;
  endfunction

  function automatic logic [7:0] tmds_dec(input logic [9:0] s);
    logic [7:0] q, d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int k = 1; k < 8; k++) d[k] = s[8] ? (q[k] ^ q[k-1]) : ~(q[k] ^ q[k-1]);
    return d;
  endfunction

  // One pixel-clock: drive inputs, queue the expected symbol if ce=1, sample at the falling edge.
  task automatic drive(input logic c, input logic [1:0] m, input logic [NUM_CH*8-1:0] d,
                       input logic [NUM_CH*2-1:0] ct, input logic [NUM_CH*4-1:0] t);
    item_t it;
    ce = c; mode = m; data = d; ctrl = ct; terc4 = t;
    if (c) begin
      it.mode = m;
      it.data = d;
      for (int i = 0; i < NUM_CH; i++) begin
        int dsp;
        dsp = mdisp[i];
        it.enc[i*10 +: 10] = ref_sym(i, m, d[i*8 +: 8], ct[i*2 +: 2], t[i*4 +: 4], dsp);
        mdisp[i] = dsp;
        it.cnt[i*8 +: 8] = 8'(dsp);
      end
      exp_q.push_back(it);
    end
    @(posedge clk);
    if (c) ce_edges++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic with_ce);
    rst = 1'b1; ce = with_ce; mode = VIDEO; data = '1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ce = 1'b0;
    exp_q.delete();
    ce_edges = 0;
    for (int i = 0; i < NUM_CH; i++) mdisp[i] = 0;
    last_enc = RST_ENC;
    last_vld = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    checks++;
    if (enc !== RST_ENC) begin errors++; $display("FAIL reset_enc: got %h want %h", enc, RST_ENC); end
    checks++;
    if (enc_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", enc_vld); end
  endtask

  task automatic test_video_zero();
    item_t      e;
    logic [9:0] lit [3];
    lit = '{10'h100, 10'h3FF, 10'h100};
    for (int p = 0; p < 5; p++) begin
      drive(1'b1, (p < 3) ? VIDEO : CTRL, '0, '0, '0);
      if (p == 0) begin
        checks++;
        if (enc_vld !== 1'b0 || enc !== RST_ENC) begin
          errors++; $display("FAIL video_first_edge: enc=%h vld=%b want enc=%h vld=0", enc, enc_vld, RST_ENC);
        end
      end else begin
        e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
        checks++;
        if (enc !== e.enc || enc_vld !== 1'b1) begin
          errors++; $display("FAIL video_zero[%0d]: enc=%h vld=%b want enc=%h vld=1", p, enc, enc_vld, e.enc);
        end
        if (p <= 3) begin
          checks++;
          if (enc[9:0] !== lit[p-1]) begin
            errors++; $display("FAIL video_zero_lane0[%0d]: got %h want %h", p, enc[9:0], lit[p-1]);
          end
        end
      end
    end
  endtask

  task automatic test_ctrl_video();
    item_t      e;
    logic [9:0] lit [5];
    logic [1:0] c;
    lit = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h100};
    for (int p = 0; p < 6; p++) begin
      c = (p < 4) ? 2'(p) : 2'd0;
      drive(1'b1, (p == 4) ? VIDEO : CTRL, '0, {NUM_CH{c}}, '0);
      e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
      checks++;
      if (enc !== e.enc || enc_vld !== 1'b1) begin
        errors++; $display("FAIL ctrl_video[%0d]: enc=%h vld=%b want enc=%h vld=1", p, enc, enc_vld, e.enc);
      end
      if (p >= 1) begin
        checks++;
        if (enc[9:0] !== lit[p-1]) begin
          errors++; $display("FAIL ctrl_video_lane0[%0d]: got %h want %h", p, enc[9:0], lit[p-1]);
        end
      end
    end
  endtask

  task automatic test_guard();
    item_t e;
    for (int p = 0; p < 2; p++) begin
      drive(1'b1, (p == 0) ? GUARD : CTRL, 24'hA5C3F0, '1, '1);
      e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
      checks++;
      if (enc !== e.enc || enc_vld !== 1'b1) begin
        errors++; $display("FAIL guard[%0d]: enc=%h vld=%b want enc=%h vld=1", p, enc, enc_vld, e.enc);
      end
      if (p == 1) begin
        for (int i = 0; i < NUM_CH; i++) begin
          checks++;
          if (enc[i*10 +: 10] !== ((i % 2 == 0) ? 10'h2CC : 10'h133)) begin
            errors++; $display("FAIL guard_lane%0d: got %h", i, enc[i*10 +: 10]);
          end
        end
      end
    end
  endtask

  task automatic test_island();
    item_t      e;
    logic [9:0] want;
    for (int p = 0; p < 3; p++) begin
      drive(1'b1, (p < 2) ? ISLAND : CTRL, '0, {NUM_CH{2'd1}}, (p == 1) ? '1 : '0);
      e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
      checks++;
      if (enc !== e.enc || enc_vld !== 1'b1) begin
        errors++; $display("FAIL island[%0d]: enc=%h vld=%b want enc=%h vld=1", p, enc, enc_vld, e.enc);
      end
      if (p >= 1) begin
        want = TERC4_ON ? ((p == 1) ? 10'h29C : 10'h2C3) : 10'h0AB;
        for (int i = 0; i < NUM_CH; i++) begin
          checks++;
          if (enc[i*10 +: 10] !== want) begin
            errors++; $display("FAIL island_lane%0d[%0d]: got %h want %h", i, p, enc[i*10 +: 10], want);
          end
        end
      end
    end
  endtask

  task automatic test_ce_stall();
    item_t      e;
    logic [9:0] lit [3];
    logic       pat [9];
    int         vcount;
    lit = '{10'h100, 10'h3FF, 10'h100};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vcount = 0;
    for (int p = 0; p < 9; p++) begin
      if (!pat[p]) begin
        drive(1'b0, GUARD, '1, '1, '1);
        checks++;
        if (enc !== last_enc || enc_vld !== last_vld) begin
          errors++; $display("FAIL ce_hold[%0d]: enc=%h vld=%b want enc=%h vld=%b", p, enc, enc_vld, last_enc, last_vld);
        end
      end else begin
        drive(1'b1, (p == 8) ? CTRL : VIDEO, '0, '0, '0);
        e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
        checks++;
        if (enc !== e.enc || enc_vld !== 1'b1) begin
          errors++; $display("FAIL ce_stall[%0d]: enc=%h vld=%b want enc=%h vld=1", p, enc, enc_vld, e.enc);
        end
        if (e.mode == VIDEO) begin
          if (vcount < 3) begin
            checks++;
            if (enc[9:0] !== lit[vcount]) begin
              errors++; $display("FAIL ce_stall_lane0[%0d]: got %h want %h", vcount, enc[9:0], lit[vcount]);
            end
          end
          vcount++;
        end
      end
    end
  endtask

  task automatic test_midreset();
    item_t e;
    drive(1'b1, VIDEO, '0, '0, '0);
    drive(1'b1, VIDEO, '0, '0, '0);
    do_reset(1'b1);
    checks++;
    if (enc !== RST_ENC || enc_vld !== 1'b0) begin
      errors++; $display("FAIL midreset_state: enc=%h vld=%b want enc=%h vld=0", enc, enc_vld, RST_ENC);
    end
    drive(1'b1, VIDEO, '0, '0, '0);
    checks++;
    if (enc !== RST_ENC || enc_vld !== 1'b0) begin
      errors++; $display("FAIL midreset_first: enc=%h vld=%b want enc=%h vld=0", enc, enc_vld, RST_ENC);
    end
    drive(1'b1, CTRL, '0, '0, '0);
    e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
    checks++;
    if (enc !== e.enc || enc_vld !== 1'b1 || enc[9:0] !== 10'h100) begin
      errors++; $display("FAIL midreset_video: enc=%h vld=%b want enc=%h (lane0 100) vld=1", enc, enc_vld, e.enc);
    end
  endtask

  task automatic test_random();
    item_t               e;
    logic [1:0]          m;
    logic                c;
    logic [NUM_CH*8-1:0] db;
    int                  dc, r;
    bit                  bad_dec, bad_cnt;
    m = VIDEO;
    for (int p = 0; p < 10000; p++) begin
      if ($urandom_range(0, 39) == 0) begin
        r = $urandom_range(0, 9);
        m = (r < 6) ? VIDEO : (r == 6) ? CTRL : (r == 7) ? ISLAND : (r == 8) ? GUARD : VIDEO;
      end
      c  = ($urandom_range(0, 9) != 0);
      db = (NUM_CH*8)'($urandom);
      drive(c, m, db, (NUM_CH*2)'($urandom), (NUM_CH*4)'($urandom));
      if (!c) begin
        checks++;
        if (enc !== last_enc || enc_vld !== last_vld) begin
          errors++; $display("FAIL rand_hold[%0d]: enc=%h vld=%b want enc=%h vld=%b", p, enc, enc_vld, last_enc, last_vld);
        end
      end else begin
        e = exp_q.pop_front(); last_enc = e.enc; last_vld = 1'b1;
        checks++;
        if (enc !== e.enc || enc_vld !== 1'b1) begin
          errors++; $display("FAIL rand_enc[%0d]: enc=%h vld=%b want enc=%h vld=1 mode=%0d", p, enc, enc_vld, e.enc, e.mode);
        end
        bad_dec = 1'b0;
        bad_cnt = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (e.mode == VIDEO && tmds_dec(enc[i*10 +: 10]) !== e.data[i*8 +: 8]) bad_dec = 1'b1;
          dc = int'($signed(dut.cnt[i]));
          if (dc != int'($signed(e.cnt[i*8 +: 8])) || dc > 10 || dc < -10) bad_cnt = 1'b1;
        end
        if (e.mode == VIDEO) begin
          checks++;
          if (bad_dec) begin
            errors++; $display("FAIL rand_decode[%0d]: enc=%h want data=%h", p, enc, e.data);
          end
        end
        checks++;
        if (bad_cnt) begin
          errors++; $display("FAIL rand_disparity[%0d]: lane0 cnt=%0d want %0d (|cnt|<=10)", p,
                             int'($signed(dut.cnt[0])), int'($signed(e.cnt[7:0])));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    ctrl_tab  = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    terc4_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                  10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                  10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                  10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    @(negedge clk);
    test_reset();
    test_video_zero();
    test_ctrl_video();
    test_guard();
    test_island();
    test_ce_stall();
    test_midreset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
